inst_encode_issue: RTL
======================

# inst_encode_issue

Instruction encoder and issue buffer that feeds the 32-bit `InstIn` word of pipeline stage 1. Upstream control logic or a testbench presents instruction fields with a valid/ready handshake. The block packs the fields into the stage-1 instruction format and buffers them in a small FIFO. It then issues one word per unstalled cycle, and drives a NOP (all zeros) when it has nothing to send.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `ADDR_WIDTH`, 2: log2(`DEPTH`).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  field set is valid this cycle.
- `in_ready`  out  1  FIFO can accept a push.
- `in_write_enable`  in  1  becomes instruction bit 30.
- `in_data_source`  in  1  becomes bit 29; 1 = immediate operand, 0 = register operand.
- `in_alu_operation`  in  3  becomes bits 28:26.
- `in_write_select`  in  5  becomes bits 25:21.
- `in_read_select_1`  in  5  becomes bits 20:16.
- `in_read_select_2`  in  5  becomes bits 15:11 when `in_data_source`=0.
- `in_immediate`  in  16  becomes bits 15:0 when `in_data_source`=1.
- `stall`  in  1  pipeline cannot take a new word this cycle.
- `InstOut`  out  32  issued instruction word; connects to stage-1 `InstIn`.
- `inst_valid`  out  1  `InstOut` holds a real instruction, not a filler NOP.
- `count`  out  `ADDR_WIDTH`+1  current FIFO occupancy.
- `issued_count`  out  16  total instructions issued since reset.

## Operation

- **Encoding** happens combinationally at push time, and the FIFO stores the 32-bit result.
  - Bit 31 is always 0.
  - `in_data_source`=1: bits 15:0 = `in_immediate`; `in_read_select_2` is ignored.
  - `in_data_source`=0: bits 15:11 = `in_read_select_2` and bits 10:0 = 0; `in_immediate` is ignored.
- **Push:**
  - A push occurs on a clock edge with `in_valid` && `in_ready`.
  - `in_ready` = (`count` < `DEPTH`), decoded from registered state.
  - `in_ready` does not look ahead to a same-cycle pop. When full, a push is refused even if a pop happens that edge.
- **Issue:** on each edge with `stall`=0:
  - FIFO non-empty: `InstOut` <= head entry, `inst_valid` <= 1, pop, `issued_count` += 1.
  - FIFO empty: `InstOut` <= 32'h0, `inst_valid` <= 0.
- **Stall:** on an edge with `stall`=1, `InstOut`, `inst_valid` and `issued_count` hold, and no pop occurs. Pushes continue while `in_ready`=1.
- **Push and pop on the same edge:** `count` is unchanged and both pointers advance.
- **No bypass:** a word pushed into an empty FIFO is not issued on that same edge.
- **Pointers** are `ADDR_WIDTH` bits and wrap from `DEPTH`-1 to 0. Occupancy is tracked by `count`.
- **`issued_count`** wraps from 16'hFFFF to 0 with no saturation.
- **Reset** has priority over everything, including mid-burst and mid-stall. It drives `InstOut`=0, `inst_valid`=0, `count`=0, `issued_count`=0 and both pointers to 0. All buffered entries are discarded, and `in_ready`=1 on the cycle after reset is released.

## Timing

- A push at edge N is issued at edge N+1 at the earliest, when the FIFO was empty and `stall`=0 at N+1. `InstOut` is then valid after N+1, which gives 1-cycle push-to-issue latency.
- Throughput is one issue per unstalled cycle and one push per cycle while not full.
- `count`, `in_ready` and the FIFO pointers update only at clock edges.
- `InstOut` is fully registered, with no combinational path from any input.
- `in_ready` depends only on registered state, never on `in_valid` or `stall`.

## Test plan

- **Reset state:** assert `reset` for 2 cycles with random inputs -> `InstOut`=0, `inst_valid`=0, `count`=0, `issued_count`=0, `in_ready`=1.
- **R-type encode:** push we=1, ds=0, alu=3'b010, ws=3, rs1=1, rs2=2, imm=16'hFFFF with `stall`=0 -> next edge `InstOut`=32'h4861_1000, `inst_valid`=1, `issued_count`=1; the edge after that `InstOut`=0, `inst_valid`=0.
- **I-type encode:** push we=1, ds=1, alu=3'b001, ws=5, rs1=4, rs2=31, imm=16'h00FF -> `InstOut`=32'h64A4_00FF.
- **Full and backpressure:** hold `stall`=1 and push 5 distinct words on consecutive cycles.
  - Expected: first 4 accepted, `count`=4, `in_ready`=0 on the 5th, `InstOut` held at 0.
  - Then drop `stall`: exactly the 4 words issue in order on consecutive edges, followed by NOP with `inst_valid`=0.
- **Steady stream with stall:** push every cycle with `stall`=0, then pulse `stall` high for 2 cycles.
  - Expected: `InstOut` holds its value during the stall, no word is lost or duplicated, and `count` rises by 2 and then drains.
- **Reset mid-operation and wrap:** with 3 entries queued, assert `reset` for 1 cycle -> all outputs are zeroed and the queued words are never issued. Separately, issue 65536 words -> `issued_count` returns to 0.

Source files
------------

// File: rtl/inst_encode_issue.sv
`default_nettype none
// inst_encode_issue: packs instruction fields into stage-1 words, buffers them in a
// small FIFO and issues one word per unstalled cycle (NOP when empty).  Rev 1.0

module inst_encode_issue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_write_enable,
  input  logic                  in_data_source,
  input  logic [2:0]            in_alu_operation,
  input  logic [4:0]            in_write_select,
  input  logic [4:0]            in_read_select_1,
  input  logic [4:0]            in_read_select_2,
  input  logic [15:0]           in_immediate,
  input  logic                  stall,
  output logic [31:0]           InstOut,
  output logic                  inst_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic [15:0]           issued_count
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [31:0]           mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [31:0]           inst_q, inst_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [15:0]           issued_q, issued_d;
  logic [31:0]           enc_word;
  logic                  push;
  logic                  pop;

  always_comb begin
    enc_word = {1'b0, in_write_enable, in_data_source, in_alu_operation,
                in_write_select, in_read_select_1, 16'h0000};
    if (in_data_source) begin
      enc_word[15:0] = in_immediate;
    end else begin
      enc_word[15:11] = in_read_select_2;
    end
  end

  // Readiness comes from registered occupancy only; a same-edge pop does not free a slot.
  assign in_ready = (count_q < FULL_COUNT);
  assign push     = in_valid && in_ready;
  assign pop      = !stall && (count_q != '0);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    issued_d     = issued_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase

    if (!stall) begin
      if (pop) begin
        inst_d       = mem_q[rd_ptr_q];
        inst_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(1);
        issued_d     = issued_q + 16'd1;
      end else begin
        inst_d       = 32'h0000_0000;
        inst_valid_d = 1'b0;
      end
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inst_q       <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
      issued_q     <= 16'h0000;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      issued_q     <= issued_d;
    end
  end

  assign InstOut      = inst_q;
  assign inst_valid   = inst_valid_q;
  assign count        = count_q;
  assign issued_count = issued_q;

endmodule

`default_nettype wire
